// File: rtl/evu_pkg.sv
// Shared types and constants for the event counter bank.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package evu_pkg;

  // Width of one mux event-select field.
  localparam int EVU_SEL_W = 4;

  // Word offsets inside one counter's 4-word register window.
  localparam logic [1:0] EVU_CTRL   = 2'd0;
  localparam logic [1:0] EVU_COUNT  = 2'd1;
  localparam logic [1:0] EVU_THRESH = 2'd2;
  localparam logic [1:0] EVU_STATUS = 2'd3;

  // STATUS bit positions.
  localparam int EVU_ST_OVF = 0;
  localparam int EVU_ST_THR = 1;

  typedef struct packed {
    logic [EVU_SEL_W-1:0] sel;
    logic                 freeze;
    logic                 irq_en;
    logic                 en;
  } evu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } evu_state_e;

  // CTRL as seen on the register bus: bit3 is a read-as-zero hole.
  function automatic logic [7:0] evu_ctrl_pack(input evu_ctrl_t c);
    return {c.sel, 1'b0, c.freeze, c.irq_en, c.en};
  endfunction

endpackage

// File: rtl/evu_counter_slice.sv
// One event counter: CTRL/COUNT/THRESH/STATUS registers plus IDLE/RUN/FROZEN FSM.
// Latency: an event counts at the next clock edge; writes take effect at the edge they are issued on.
// Backpressure: none; write strobes are accepted every cycle.
// Ports: clk_i/rst_i clock and async active-high reset; event_i mux event; debug_mode_i inhibit;
//        *_we_i per-register write strobes with wdata_i; ctrl_o/count_o/thresh_o/status_o register
//        state for the read mux; irq_o this counter's (unregistered) interrupt contribution.
module evu_counter_slice
  import evu_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 event_i,
  input  logic                 debug_mode_i,
  input  logic                 ctrl_we_i,
  input  logic                 count_we_i,
  input  logic                 thresh_we_i,
  input  logic                 status_we_i,
  input  logic [CNT_WIDTH-1:0] wdata_i,
  output evu_ctrl_t            ctrl_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [CNT_WIDTH-1:0] thresh_o,
  output logic [1:0]           status_o,
  output logic                 irq_o
);

  evu_ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] thresh_q, thresh_d;
  logic [1:0]           status_q, status_d;
  evu_state_e           state_q, state_d;

  logic                 inc;
  logic                 ovf;
  logic                 thr_hit;
  logic [CNT_WIDTH-1:0] cnt_plus;

  always_comb begin
    // Increment is judged on the current (pre-write) state, so a CTRL write
    // in the same cycle does not affect whether this cycle's event counts.
    inc      = (state_q == RUN) && event_i && !debug_mode_i;
    cnt_plus = count_q + CNT_WIDTH'(1);
    // A COUNT write drops the colliding increment, including its overflow.
    ovf      = inc && (&count_q) && !count_we_i;

    ctrl_d = ctrl_q;
    if (ctrl_we_i) begin
      ctrl_d.en     = wdata_i[0];
      ctrl_d.irq_en = wdata_i[1];
      ctrl_d.freeze = wdata_i[2];
      ctrl_d.sel    = wdata_i[7:4];
    end

    count_d = count_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (inc && !(ovf && ctrl_q.freeze)) begin
      count_d = cnt_plus;  // wraps to 0 on overflow without freeze
    end

    thresh_d = thresh_q;
    if (thresh_we_i) begin
      thresh_d = wdata_i;
    end

    // Post-increment comparison; THRESH of 0 disables the match.
    thr_hit = inc && !count_we_i && (thresh_q != '0) && (count_d == thresh_q);

    // Sticky bits; a W1C in the same cycle wins over the hardware set.
    status_d[EVU_ST_OVF] = (status_q[EVU_ST_OVF] | ovf)
                           & ~(status_we_i & wdata_i[EVU_ST_OVF]);
    status_d[EVU_ST_THR] = (status_q[EVU_ST_THR] | thr_hit)
                           & ~(status_we_i & wdata_i[EVU_ST_THR]);

    state_d = state_q;
    if (ctrl_we_i) begin
      state_d = wdata_i[0] ? RUN : IDLE;
    end else if (count_we_i && (state_q == FROZEN)) begin
      state_d = ctrl_q.en ? RUN : IDLE;
    end else if (ovf && ctrl_q.freeze) begin
      state_d = FROZEN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      count_q  <= '0;
      thresh_q <= '0;
      status_q <= '0;
      state_q  <= IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      status_q <= status_d;
      state_q  <= state_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign count_o  = count_q;
  assign thresh_o = thresh_q;
  assign status_o = status_q;
  assign irq_o    = ctrl_q.irq_en & (|status_q);

endmodule

// File: rtl/evu_counter_bank.sv
// Bank of programmable event counters feeding per-counter mux selects, with a CSR register port.
// Latency: read data and rvalid one cycle after the request; writes complete in the request cycle; irq registered.
// Backpressure: none; the register port accepts one access every cycle.
// Ports: clk_i/rst_i clock and async active-high reset; event_i per-counter events; sel_o 4-bit
//        select per counter; debug_mode_i count inhibit; reg_* single-cycle register port; irq_o interrupt.
module evu_counter_bank
  import evu_pkg::*;
#(
  parameter int NR_COUNTERS = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = $clog2(NR_COUNTERS) + 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_COUNTERS-1:0]       event_i,
  output logic [NR_COUNTERS*4-1:0]     sel_o,
  input  logic                         debug_mode_i,
  input  logic                         reg_req_i,
  input  logic                         reg_we_i,
  input  logic [ADDR_WIDTH-1:0]        reg_addr_i,
  input  logic [DATA_WIDTH-1:0]        reg_wdata_i,
  output logic                         reg_rvalid_o,
  output logic [DATA_WIDTH-1:0]        reg_rdata_o,
  output logic                         irq_o
);

  // Counter index kept at full address width so index values beyond
  // NR_COUNTERS stay distinguishable (they decode to nothing).
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;

  evu_ctrl_t            ctrl_arr   [NR_COUNTERS];
  logic [CNT_WIDTH-1:0] count_arr  [NR_COUNTERS];
  logic [CNT_WIDTH-1:0] thresh_arr [NR_COUNTERS];
  logic [1:0]           status_arr [NR_COUNTERS];
  logic [NR_COUNTERS-1:0] irq_vec;

  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx = reg_addr_i >> 2;
  assign off = reg_addr_i[1:0];

  for (genvar i = 0; i < NR_COUNTERS; i++) begin : g_slice
    logic wr_hit;
    assign wr_hit = reg_req_i && reg_we_i && (idx == ADDR_WIDTH'(i));

    evu_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_slice (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .event_i      (event_i[i]),
      .debug_mode_i (debug_mode_i),
      .ctrl_we_i    (wr_hit && (off == EVU_CTRL)),
      .count_we_i   (wr_hit && (off == EVU_COUNT)),
      .thresh_we_i  (wr_hit && (off == EVU_THRESH)),
      .status_we_i  (wr_hit && (off == EVU_STATUS)),
      .wdata_i      (reg_wdata_i[CNT_WIDTH-1:0]),
      .ctrl_o       (ctrl_arr[i]),
      .count_o      (count_arr[i]),
      .thresh_o     (thresh_arr[i]),
      .status_o     (status_arr[i]),
      .irq_o        (irq_vec[i])
    );

    assign sel_o[4*i +: 4] = ctrl_arr[i].sel;
  end

  // Read mux over pre-update register values; unmapped indices return 0.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NR_COUNTERS; k++) begin
      if (idx == ADDR_WIDTH'(k)) begin
        case (off)
          EVU_CTRL:   rd_word[7:0]           = evu_ctrl_pack(ctrl_arr[k]);
          EVU_COUNT:  rd_word[CNT_WIDTH-1:0] = count_arr[k];
          EVU_THRESH: rd_word[CNT_WIDTH-1:0] = thresh_arr[k];
          default:    rd_word[1:0]           = status_arr[k];
        endcase
      end
    end
  end

  always_comb begin
    rvalid_d = reg_req_i && !reg_we_i;
    rdata_d  = rvalid_d ? rd_word : rdata_q;  // hold last read data
    irq_d    = |irq_vec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_evu_counter_bank.sv
// Directed bench for evu_counter_bank: counting, debug inhibit, wrap, freeze, threshold, reset/unmapped.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_evu_counter_bank;

  localparam int N  = 4;
  localparam int CW = 64;
  localparam int DW = 64;
  localparam int AW = 5;  // one spare bit so an unmapped index is addressable

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   event_i;
  logic [N*4-1:0] sel_o;
  logic           debug_mode_i;
  logic           reg_req_i;
  logic           reg_we_i;
  logic [AW-1:0]  reg_addr_i;
  logic [DW-1:0]  reg_wdata_i;
  logic           reg_rvalid_o;
  logic [DW-1:0]  reg_rdata_o;
  logic           irq_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  evu_counter_bank #(
    .NR_COUNTERS (N),
    .CNT_WIDTH   (CW),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .event_i      (event_i),
    .sel_o        (sel_o),
    .debug_mode_i (debug_mode_i),
    .reg_req_i    (reg_req_i),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_rdata_o  (reg_rdata_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    reg_req_i   = 1'b1;
    reg_we_i    = 1'b1;
    reg_addr_i  = a;
    reg_wdata_i = d;
    @(posedge clk_i); #1;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic rv, output logic [63:0] d);
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = a;
    @(posedge clk_i); #1;
    reg_req_i  = 1'b0;
    rv = reg_rvalid_o;
    d  = reg_rdata_o;
  endtask

  initial begin
    logic        rv;
    logic [63:0] d;

    rst_i        = 1'b1;
    event_i      = '0;
    debug_mode_i = 1'b0;
    reg_req_i    = 1'b0;
    reg_we_i     = 1'b0;
    reg_addr_i   = '0;
    reg_wdata_i  = '0;

    // Reset state
    repeat (2) @(posedge clk_i); #1;
    chk("rst_sel", 64'(sel_o), 64'h0);
    chk("rst_rvalid", 64'(reg_rvalid_o), 64'h0);
    chk("rst_rdata", reg_rdata_o, 64'h0);
    chk("rst_irq", 64'(irq_o), 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Counting: CTRL0 = EN, SEL=2; 5 events
    wr(5'd0, 64'h21);
    chk("sel0", 64'(sel_o[3:0]), 64'h2);
    event_i[0] = 1'b1;
    repeat (5) @(posedge clk_i); #1;
    event_i[0] = 1'b0;
    chk("rvalid_idle", 64'(reg_rvalid_o), 64'h0);
    rd(5'd1, rv, d);
    chk("cnt0_rvalid", 64'(rv), 64'h1);
    chk("cnt0", d, 64'd5);
    @(posedge clk_i); #1;
    chk("rvalid_pulse", 64'(reg_rvalid_o), 64'h0);
    chk("rdata_hold", reg_rdata_o, 64'd5);
    rd(5'd0, rv, d);
    chk("ctrl0_rd", d, 64'h21);

    // Debug inhibit: 4 event cycles, debug high for the middle two
    wr(5'd4, 64'h01);
    event_i[1] = 1'b1;
    @(posedge clk_i); #1;
    debug_mode_i = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    debug_mode_i = 1'b0;
    @(posedge clk_i); #1;
    event_i[1] = 1'b0;
    rd(5'd5, rv, d);
    chk("cnt1_debug", d, 64'd2);

    // Wrap: CTRL2 = EN|IRQ_EN, COUNT2 = all-ones, one event
    wr(5'd8, 64'h03);
    wr(5'd9, ONES);
    event_i[2] = 1'b1;
    @(posedge clk_i); #1;
    event_i[2] = 1'b0;
    chk("irq_1cyc", 64'(irq_o), 64'h0);
    @(posedge clk_i); #1;
    chk("irq_2cyc", 64'(irq_o), 64'h1);
    rd(5'd9, rv, d);
    chk("cnt2_wrap", d, 64'h0);
    rd(5'd11, rv, d);
    chk("st2_ovf", d, 64'h1);
    wr(5'd11, 64'h1);
    chk("irq_w1c_same", 64'(irq_o), 64'h1);
    @(posedge clk_i); #1;
    chk("irq_w1c_next", 64'(irq_o), 64'h0);

    // Freeze: CTRL2 = EN|IRQ_EN|FREEZE, COUNT2 = all-ones, 3 events
    wr(5'd8, 64'h07);
    wr(5'd9, ONES);
    event_i[2] = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    event_i[2] = 1'b0;
    rd(5'd9, rv, d);
    chk("cnt2_frozen", d, ONES);
    rd(5'd11, rv, d);
    chk("st2_frz_ovf", d, 64'h1);
    wr(5'd9, 64'h0);
    event_i[2] = 1'b1;
    @(posedge clk_i); #1;
    event_i[2] = 1'b0;
    rd(5'd9, rv, d);
    chk("cnt2_resume", d, 64'h1);
    wr(5'd8, 64'h0);
    wr(5'd11, 64'h3);

    // Threshold with COUNT-write collision on the 3rd event
    wr(5'd12, 64'h01);
    wr(5'd14, 64'd3);
    event_i[3] = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    reg_req_i   = 1'b1;
    reg_we_i    = 1'b1;
    reg_addr_i  = 5'd13;
    reg_wdata_i = 64'd10;
    @(posedge clk_i); #1;
    reg_req_i  = 1'b0;
    reg_we_i   = 1'b0;
    event_i[3] = 1'b0;
    rd(5'd13, rv, d);
    chk("cnt3_collide", d, 64'd10);
    rd(5'd15, rv, d);
    chk("st3_no_hit", d, 64'h0);
    wr(5'd14, 64'd12);
    event_i[3] = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    event_i[3] = 1'b0;
    rd(5'd15, rv, d);
    chk("st3_thr_hit", d, 64'h2);
    rd(5'd13, rv, d);
    chk("cnt3_final", d, 64'd12);

    // Reset with a read request pending at the next edge
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = 5'd1;
    #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    reg_req_i = 1'b0;
    chk("rstmid_rvalid", 64'(reg_rvalid_o), 64'h0);
    chk("rstmid_rdata", reg_rdata_o, 64'h0);
    chk("rstmid_sel", 64'(sel_o), 64'h0);
    chk("rstmid_irq", 64'(irq_o), 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_no_rvalid", 64'(reg_rvalid_o), 64'h0);
    rd(5'd1, rv, d);
    chk("cnt0_cleared", d, 64'h0);

    // Unmapped access: writes ignored, reads give 0 with rvalid
    wr(5'd16, 64'hF1);
    chk("unmap_wr_sel", 64'(sel_o), 64'h0);
    wr(5'd1, 64'h55);
    rd(5'd1, rv, d);
    chk("cnt0_wr", d, 64'h55);
    rd(5'd16, rv, d);
    chk("unmap_rvalid", 64'(rv), 64'h1);
    chk("unmap_rdata", d, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evu_counter_bank.md
Name: evu_counter_bank

Overview:
- Event counter bank that sits directly downstream of the per-event selection muxes.
- Holds NR_COUNTERS programmable counters. Counter i drives the 4-bit event select of mux instance i and consumes that mux's 1-bit event output.
- Provides a single-cycle register interface for CSR access, plus overflow and threshold status with an interrupt line to the CSR file.

Parameters:
- NR_COUNTERS, 4, number of counters (and of upstream mux instances); range 1..16.
- CNT_WIDTH, 64, width of each counter and threshold register.
- DATA_WIDTH, 64, register-interface data width; must be >= CNT_WIDTH.
- ADDR_WIDTH, $clog2(NR_COUNTERS)+2, register word-address width.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- event_i  in  NR_COUNTERS  per-counter event pulses (mux outputs), sampled every cycle
- sel_o  out  NR_COUNTERS*4  per-counter event select; bits [4i+3:4i] feed mux i
- debug_mode_i  in  1  when high, no counter increments
- reg_req_i  in  1  register access strobe
- reg_we_i  in  1  1 = write, 0 = read
- reg_addr_i  in  ADDR_WIDTH  {counter index, offset[1:0]}
- reg_wdata_i  in  DATA_WIDTH  write data
- reg_rvalid_o  out  1  read data valid
- reg_rdata_o  out  DATA_WIDTH  read data
- irq_o  out  1  registered interrupt request

Behaviour:
- Register map for counter i; the word address is i*4 + offset.
  - Offset 0, CTRL:
    - bit0 EN
    - bit1 IRQ_EN
    - bit2 FREEZE_ON_OVF
    - bits[7:4] SEL
    - other bits read 0
  - Offset 1, COUNT: R/W.
  - Offset 2, THRESH: R/W.
  - Offset 3, STATUS: bit0 OVF, bit1 THR_HIT. Both are sticky; writing 1 clears the bit (W1C).
- Reset: all CTRL, COUNT, THRESH and STATUS fields are 0. sel_o=0, reg_rvalid_o=0, reg_rdata_o=0, irq_o=0. Every counter FSM is in IDLE.
- sel_o is driven combinationally from the CTRL.SEL fields.
- Per-counter FSM:
  - IDLE: EN=0; the counter holds its value.
  - RUN: EN=1.
  - FROZEN: overflow occurred while FREEZE_ON_OVF=1.
  - Transitions:
    - IDLE->RUN on a CTRL write with EN=1.
    - RUN->IDLE on a CTRL write with EN=0.
    - RUN->FROZEN on overflow with FREEZE_ON_OVF=1.
    - FROZEN->IDLE/RUN on any CTRL write (per the written EN), or on a COUNT write (the FSM returns to RUN if EN=1).
- Increment condition: state RUN && event_i[i] && !debug_mode_i. COUNT updates at the next clock edge, so the increment is visible one cycle after the event.
- Overflow: COUNT is all-ones and an increment occurs.
  - OVF is set in all cases.
  - If FREEZE_ON_OVF=0, COUNT wraps to 0.
  - If FREEZE_ON_OVF=1, COUNT holds all-ones and the FSM enters FROZEN.
- Threshold: THR_HIT is set when THRESH != 0 and the post-increment COUNT equals THRESH. A THRESH value of 0 disables the threshold function.
- Simultaneous events within the same cycle:
  - A software write to COUNT beats an increment; the increment is dropped.
  - A W1C of a STATUS bit beats a hardware set of that bit; the event is lost.
  - A CTRL write that changes SEL takes effect for the next cycle's event_i. The current cycle's event is still counted under the old state.
- Reads:
  - reg_rvalid_o pulses for one cycle, one cycle after a read request.
  - reg_rdata_o returns the pre-update register value, zero-extended to DATA_WIDTH.
  - reg_rdata_o holds its value when reg_rvalid_o=0.
- Writes complete in the cycle they are requested and produce no response.
- Unmapped accesses (counter index >= NR_COUNTERS) read 0 with reg_rvalid_o=1; writes to them are ignored.
- irq_o is registered: irq_o(next) = OR over i of (IRQ_EN_i & (OVF_i | THR_HIT_i)).
- Asserting reset mid-operation clears everything asynchronously. Any read in flight is discarded (no rvalid).

Decomposition:
- Shared package (ariane_pkg or a new evu_pkg):
  - evu_ctrl_t struct (en, irq_en, freeze, sel[3:0])
  - evu_state_e enum (IDLE, RUN, FROZEN)
  - Register offset constants EVU_CTRL=0, EVU_COUNT=1, EVU_THRESH=2, EVU_STATUS=3
- Natural sub-module: evu_counter_slice, covering one counter's FSM, COUNT, THRESH and STATUS. The bank instantiates it NR_COUNTERS times in a generate loop and contains the address decode, read mux and irq OR.

Test Plan:
- Counting: write CTRL0 = 0x21 (EN, SEL=2); drive event_i[0] high for 5 cycles -> a read of COUNT0 returns 5, sel_o[3:0]=2, rvalid is seen 1 cycle after the request.
- Debug inhibit: counter 1 in RUN; event_i[1]=1 for 4 cycles with debug_mode_i=1 for 2 of them -> COUNT1=2.
- Wrap: write COUNT2 = all-ones with FREEZE=0 and IRQ_EN=1; one event -> COUNT2=0, STATUS2.OVF=1, irq_o=1 two cycles after the event. Writing STATUS2=1 -> irq_o=0 on the following cycle.
- Freeze: same setup with FREEZE=1; 3 events -> COUNT2 stays all-ones and the FSM is FROZEN. Writing COUNT2=0 -> the counter resumes and 1 further event gives COUNT2=1.
- Threshold and collision: THRESH3=3; on the cycle of the 3rd event, simultaneously write COUNT3=10 -> COUNT3=10 and THR_HIT stays 0. Then set THRESH3=12; 2 events -> THR_HIT=1.
- Reset and unmapped access: assert rst_i during an outstanding read -> all outputs 0 and no rvalid. After reset, a read of address NR_COUNTERS*4 -> rvalid=1, rdata=0.
